// File: rtl/core_wb_arbiter_pkg.sv
// Shared widths and grant-source encoding for the writeback arbiter.
// Both ports of the register file write path agree on these widths.
package core_wb_arbiter_pkg;

  localparam int CPU_RFIDX_WIDTH  = 5;
  localparam int CPU_RFDATA_WIDTH = 64;
  localparam int CPU_REGS_NUM     = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_FIFO = 2'd2
  } gnt_src_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/core_wb_fifo.sv
// Small synchronous FIFO holding MDU results (destination index plus data)
// until the register file write port is granted to them.
module core_wb_fifo
  import core_wb_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int IDX_W  = CPU_RFIDX_WIDTH,
  parameter int DATA_W = CPU_RFDATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [IDX_W-1:0]  push_idx,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [IDX_W-1:0]  head_idx,
  output logic [DATA_W-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0]  mem_idx  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is refused even when a pop frees a slot that cycle.
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_idx  = mem_idx[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_idx[wr_ptr]  <= push_idx;
      mem_data[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// Shares the register file write port between pipeline writeback and buffered
// MDU results, and tracks MDU-pending destinations to stall decode.
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int IDX_W        = CPU_RFIDX_WIDTH,
  parameter int DATA_W       = CPU_RFDATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_valid,
  output logic              pipe_wb_ready,
  input  logic [IDX_W-1:0]  pipe_wb_idx,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              mdu_iss_valid,
  output logic              mdu_iss_ready,
  input  logic [IDX_W-1:0]  mdu_iss_idx,
  input  logic              mdu_res_valid,
  output logic              mdu_res_ready,
  input  logic [IDX_W-1:0]  mdu_res_idx,
  input  logic [DATA_W-1:0] mdu_res_data,
  input  logic [IDX_W-1:0]  hz_r1_idx,
  input  logic [IDX_W-1:0]  hz_r2_idx,
  input  logic [IDX_W-1:0]  hz_rd_idx,
  output logic              hz_stall,
  output logic              rf_wen,
  output logic [IDX_W-1:0]  wr_indx,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       conflict_cnt
);

  localparam int REGS = 2 ** IDX_W;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [IDX_W-1:0]  head_idx;
  logic [DATA_W-1:0] head_data;
  logic              force_fifo;
  logic              iss_fire;
  logic [SW-1:0]     starve_cnt;
  logic [REGS-1:0]   pend;
  logic [REGS-1:0]   pend_nxt;
  gnt_src_e          gnt;

  core_wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_idx  (mdu_res_idx),
    .push_data (mdu_res_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_idx  (head_idx),
    .head_data (head_data)
  );

  assign force_fifo    = (starve_cnt == STARVE_MAX) & ~fifo_empty;
  assign fifo_push     = mdu_res_valid & ~fifo_full;
  assign fifo_pop      = (gnt == GNT_FIFO);
  assign pipe_wb_ready = ~force_fifo;
  assign mdu_res_ready = ~fifo_full;
  assign mdu_iss_ready = ~pend[mdu_iss_idx];
  assign iss_fire      = mdu_iss_valid & mdu_iss_ready & (mdu_iss_idx != '0);
  assign hz_stall      = pend[hz_r1_idx] | pend[hz_r2_idx] | pend[hz_rd_idx];

  // A starved FIFO head overrides the pipeline; otherwise the pipeline has priority.
  always_comb begin
    gnt = GNT_NONE;
    if (force_fifo)         gnt = GNT_FIFO;
    else if (pipe_wb_valid) gnt = GNT_PIPE;
    else if (!fifo_empty)   gnt = GNT_FIFO;
  end

  always_comb begin
    rf_wen  = 1'b0;
    wr_indx = pipe_wb_idx;
    wr_data = pipe_wb_data;
    case (gnt)
      GNT_PIPE: rf_wen = (pipe_wb_idx != '0);
      GNT_FIFO: begin
        wr_indx = head_idx;
        wr_data = head_data;
        rf_wen  = (head_idx != '0);
      end
      default: rf_wen = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (fifo_empty || gnt == GNT_FIFO)
        starve_cnt <= '0;
      else if (gnt == GNT_PIPE && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + SW'(1);
      if (!fifo_empty && gnt == GNT_PIPE)
        conflict_cnt <= sat_inc32(conflict_cnt);
    end
  end

  // Clearing on pop and setting on issue never target the same register in one cycle.
  always_comb begin
    pend_nxt = pend;
    if (fifo_pop) pend_nxt[head_idx] = 1'b0;
    if (iss_fire) pend_nxt[mdu_iss_idx] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Testbench for core_wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_core_wb_arbiter;
  import core_wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int SLIM  = 4;
  localparam int IW    = 5;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_wb_valid;
  logic          pipe_wb_ready;
  logic [IW-1:0] pipe_wb_idx;
  logic [DW-1:0] pipe_wb_data;
  logic          mdu_iss_valid;
  logic          mdu_iss_ready;
  logic [IW-1:0] mdu_iss_idx;
  logic          mdu_res_valid;
  logic          mdu_res_ready;
  logic [IW-1:0] mdu_res_idx;
  logic [DW-1:0] mdu_res_data;
  logic [IW-1:0] hz_r1_idx;
  logic [IW-1:0] hz_r2_idx;
  logic [IW-1:0] hz_rd_idx;
  logic          hz_stall;
  logic          rf_wen;
  logic [IW-1:0] wr_indx;
  logic [DW-1:0] wr_data;
  logic [31:0]   conflict_cnt;

  always #5 clk = ~clk;

  core_wb_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (SLIM),
    .IDX_W        (IW),
    .DATA_W       (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_ready (pipe_wb_ready),
    .pipe_wb_idx   (pipe_wb_idx),
    .pipe_wb_data  (pipe_wb_data),
    .mdu_iss_valid (mdu_iss_valid),
    .mdu_iss_ready (mdu_iss_ready),
    .mdu_iss_idx   (mdu_iss_idx),
    .mdu_res_valid (mdu_res_valid),
    .mdu_res_ready (mdu_res_ready),
    .mdu_res_idx   (mdu_res_idx),
    .mdu_res_data  (mdu_res_data),
    .hz_r1_idx     (hz_r1_idx),
    .hz_r2_idx     (hz_r2_idx),
    .hz_rd_idx     (hz_rd_idx),
    .hz_stall      (hz_stall),
    .rf_wen        (rf_wen),
    .wr_indx       (wr_indx),
    .wr_data       (wr_data),
    .conflict_cnt  (conflict_cnt)
  );

  // Reference model: buffered results as a queue, pending registers as a bit set.
  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          m_q[$];
  bit   [31:0]   m_pend;
  int            m_starve;
  longint        m_conf;
  bit            g_fifo, g_pipe;
  bit            e_ready, e_wen, e_res_ready, e_iss_ready, e_stall;
  logic [IW-1:0] e_idx;
  logic [DW-1:0] e_data;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic void model_eval();
    bit has, forced;
    has    = (m_q.size() != 0);
    forced = has && (m_starve == SLIM);
    g_fifo = forced || (has && !pipe_wb_valid);
    g_pipe = !forced && pipe_wb_valid;
    e_ready = !forced;
    if (g_fifo) begin
      e_idx  = m_q[0].idx;
      e_data = m_q[0].data;
    end else begin
      e_idx  = pipe_wb_idx;
      e_data = pipe_wb_data;
    end
    e_wen       = (g_fifo || g_pipe) && (e_idx != 0);
    e_res_ready = (m_q.size() < DEPTH);
    e_iss_ready = !m_pend[mdu_iss_idx];
    e_stall     = m_pend[hz_r1_idx] || m_pend[hz_r2_idx] || m_pend[hz_rd_idx];
  endfunction

  function automatic void model_step();
    int   pre;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_pend   = '0;
      m_starve = 0;
      m_conf   = 0;
      return;
    end
    model_eval();
    pre = m_q.size();
    if (g_fifo) begin
      m_pend[m_q[0].idx] = 1'b0;
      void'(m_q.pop_front());
    end
    if (mdu_res_valid && pre < DEPTH) begin
      e.idx  = mdu_res_idx;
      e.data = mdu_res_data;
      m_q.push_back(e);
    end
    if (mdu_iss_valid && e_iss_ready && mdu_iss_idx != 0) m_pend[mdu_iss_idx] = 1'b1;
    m_pend[0] = 1'b0;
    if (pre == 0 || g_fifo) m_starve = 0;
    else if (g_pipe)        m_starve = m_starve + 1;
    if (pre != 0 && g_pipe && m_conf < 64'hFFFF_FFFF) m_conf = m_conf + 1;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    pipe_wb_valid = 0; pipe_wb_idx = 0; pipe_wb_data = 0;
    mdu_iss_valid = 0; mdu_iss_idx = 0;
    mdu_res_valid = 0; mdu_res_idx = 0; mdu_res_data = 0;
    hz_r1_idx = 0; hz_r2_idx = 0; hz_rd_idx = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rf_wen !== 1'b0) $display("[TB] FAIL reset_rf_wen: got %b want 0", rf_wen); else n_pass++;
    n_checks++; if (pipe_wb_ready !== 1'b1) $display("[TB] FAIL reset_pipe_ready: got %b want 1", pipe_wb_ready); else n_pass++;
    n_checks++; if (mdu_res_ready !== 1'b1) $display("[TB] FAIL reset_res_ready: got %b want 1", mdu_res_ready); else n_pass++;
    n_checks++; if (mdu_iss_ready !== 1'b1) $display("[TB] FAIL reset_iss_ready: got %b want 1", mdu_iss_ready); else n_pass++;
    n_checks++; if (hz_stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", hz_stall); else n_pass++;
    n_checks++; if (conflict_cnt !== 32'd0) $display("[TB] FAIL reset_conflict: got %0d want 0", conflict_cnt); else n_pass++;
  endtask

  task automatic test_pipe_only();
    do_reset();
    pipe_wb_valid = 1; pipe_wb_idx = 5; pipe_wb_data = 64'hAA;
    #2;
    n_checks++; if (rf_wen !== 1'b1) $display("[TB] FAIL pipe_wen: got %b want 1", rf_wen); else n_pass++;
    n_checks++; if (wr_indx !== 5'd5) $display("[TB] FAIL pipe_idx: got %0d want 5", wr_indx); else n_pass++;
    n_checks++; if (wr_data !== 64'hAA) $display("[TB] FAIL pipe_data: got %h want aa", wr_data); else n_pass++;
    n_checks++; if (pipe_wb_ready !== 1'b1) $display("[TB] FAIL pipe_ready: got %b want 1", pipe_wb_ready); else n_pass++;
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    mdu_iss_valid = 1; mdu_iss_idx = 7;
    #2;
    tick();
    mdu_iss_valid = 0;
    mdu_res_valid = 1; mdu_res_idx = 7; mdu_res_data = 64'h77;
    pipe_wb_valid = 1; pipe_wb_idx = 3; pipe_wb_data = 64'h33;
    hz_r1_idx = 7;
    #2;
    tick();
    mdu_res_valid = 0;
    for (int k = 0; k < SLIM; k++) begin
      #2;
      n_checks++; if (pipe_wb_ready !== 1'b1 || wr_indx !== 5'd3) $display("[TB] FAIL contend_pipe_wins[%0d]: got ready=%b idx=%0d want ready=1 idx=3", k, pipe_wb_ready, wr_indx); else n_pass++;
      tick();
    end
    #2;
    n_checks++; if (pipe_wb_ready !== 1'b0) $display("[TB] FAIL contend_force_ready: got %b want 0", pipe_wb_ready); else n_pass++;
    n_checks++; if (rf_wen !== 1'b1 || wr_indx !== 5'd7 || wr_data !== 64'h77) $display("[TB] FAIL contend_force_write: got wen=%b idx=%0d data=%h want 1/7/77", rf_wen, wr_indx, wr_data); else n_pass++;
    n_checks++; if (hz_stall !== 1'b1) $display("[TB] FAIL contend_stall_held: got %b want 1", hz_stall); else n_pass++;
    tick();
    n_checks++; if (hz_stall !== 1'b0) $display("[TB] FAIL contend_pend_clear: got %b want 0", hz_stall); else n_pass++;
    n_checks++; if (conflict_cnt !== 32'd4) $display("[TB] FAIL contend_conflict: got %0d want 4", conflict_cnt); else n_pass++;
    n_checks++; if (pipe_wb_ready !== 1'b1) $display("[TB] FAIL contend_ready_back: got %b want 1", pipe_wb_ready); else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    do_reset();
    mdu_iss_valid = 1; mdu_iss_idx = 9;
    #2;
    tick();
    mdu_iss_valid = 0; hz_r1_idx = 9;
    #2;
    n_checks++; if (hz_stall !== 1'b1) $display("[TB] FAIL sb_stall_r1: got %b want 1", hz_stall); else n_pass++;
    n_checks++; if (mdu_iss_ready !== 1'b0) $display("[TB] FAIL sb_iss_blocked: got %b want 0", mdu_iss_ready); else n_pass++;
    hz_r1_idx = 0; hz_rd_idx = 9;
    #1;
    n_checks++; if (hz_stall !== 1'b1) $display("[TB] FAIL sb_stall_rd: got %b want 1", hz_stall); else n_pass++;
    mdu_res_valid = 1; mdu_res_idx = 9; mdu_res_data = 64'h99;
    #1;
    tick();
    mdu_res_valid = 0;
    #2;
    n_checks++; if (rf_wen !== 1'b1 || wr_indx !== 5'd9) $display("[TB] FAIL sb_result_write: got wen=%b idx=%0d want 1/9", rf_wen, wr_indx); else n_pass++;
    n_checks++; if (mdu_iss_ready !== 1'b0) $display("[TB] FAIL sb_same_cycle_clear: got %b want 0", mdu_iss_ready); else n_pass++;
    tick();
    n_checks++; if (hz_stall !== 1'b0) $display("[TB] FAIL sb_stall_released: got %b want 0", hz_stall); else n_pass++;
    n_checks++; if (mdu_iss_ready !== 1'b1) $display("[TB] FAIL sb_iss_released: got %b want 1", mdu_iss_ready); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    mdu_iss_valid = 1; mdu_iss_idx = 0;
    #2;
    tick();
    mdu_iss_valid = 0; hz_r1_idx = 0;
    #2;
    n_checks++; if (hz_stall !== 1'b0 || mdu_iss_ready !== 1'b1) $display("[TB] FAIL x0_no_pend: got stall=%b iss_ready=%b want 0/1", hz_stall, mdu_iss_ready); else n_pass++;
    mdu_res_valid = 1; mdu_res_idx = 0; mdu_res_data = 64'h10;
    #2;
    tick();
    mdu_res_idx = 12; mdu_res_data = 64'hC0;
    #2;
    n_checks++; if (rf_wen !== 1'b0) $display("[TB] FAIL x0_no_write: got %b want 0", rf_wen); else n_pass++;
    tick();
    mdu_res_valid = 0;
    #2;
    n_checks++; if (rf_wen !== 1'b1 || wr_indx !== 5'd12 || wr_data !== 64'hC0) $display("[TB] FAIL x0_popped: got wen=%b idx=%0d data=%h want 1/12/c0", rf_wen, wr_indx, wr_data); else n_pass++;
    tick();
  endtask

  task automatic test_full();
    do_reset();
    pipe_wb_valid = 1; pipe_wb_idx = 1; pipe_wb_data = 64'h1;
    mdu_res_valid = 1; mdu_res_idx = 10; mdu_res_data = 64'hA0;
    #2;
    tick();
    mdu_res_idx = 11; mdu_res_data = 64'hB0;
    #2;
    tick();
    mdu_res_idx = 13; mdu_res_data = 64'hD0;
    #2;
    n_checks++; if (mdu_res_ready !== 1'b0) $display("[TB] FAIL full_ready: got %b want 0", mdu_res_ready); else n_pass++;
    tick();
    pipe_wb_valid = 0;
    #2;
    n_checks++; if (mdu_res_ready !== 1'b0 || wr_indx !== 5'd10 || wr_data !== 64'hA0) $display("[TB] FAIL full_drain0: got ready=%b idx=%0d data=%h want 0/10/a0", mdu_res_ready, wr_indx, wr_data); else n_pass++;
    tick();
    n_checks++; if (mdu_res_ready !== 1'b1 || wr_indx !== 5'd11 || wr_data !== 64'hB0) $display("[TB] FAIL full_drain1: got ready=%b idx=%0d data=%h want 1/11/b0", mdu_res_ready, wr_indx, wr_data); else n_pass++;
    tick();
    mdu_res_valid = 0;
    #2;
    n_checks++; if (rf_wen !== 1'b1 || wr_indx !== 5'd13 || wr_data !== 64'hD0) $display("[TB] FAIL full_drain2: got wen=%b idx=%0d data=%h want 1/13/d0", rf_wen, wr_indx, wr_data); else n_pass++;
    tick();
    n_checks++; if (rf_wen !== 1'b0) $display("[TB] FAIL full_drained: got %b want 0", rf_wen); else n_pass++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    mdu_iss_valid = 1; mdu_iss_idx = 20;
    #2;
    tick();
    mdu_iss_idx = 21;
    pipe_wb_valid = 1; pipe_wb_idx = 2;
    mdu_res_valid = 1; mdu_res_idx = 20; mdu_res_data = 64'h20;
    #2;
    tick();
    mdu_iss_valid = 0;
    mdu_res_idx = 21; mdu_res_data = 64'h21;
    #2;
    tick();
    idle_inputs();
    hz_r1_idx = 20; hz_r2_idx = 21;
    rst = 1;
    #2;
    n_checks++; if (hz_stall !== 1'b1 || mdu_res_ready !== 1'b0) $display("[TB] FAIL midop_busy: got stall=%b res_ready=%b want 1/0", hz_stall, mdu_res_ready); else n_pass++;
    tick();
    rst = 0;
    #2;
    n_checks++; if (hz_stall !== 1'b0) $display("[TB] FAIL midop_pend: got %b want 0", hz_stall); else n_pass++;
    n_checks++; if (mdu_res_ready !== 1'b1 || rf_wen !== 1'b0) $display("[TB] FAIL midop_empty: got res_ready=%b wen=%b want 1/0", mdu_res_ready, rf_wen); else n_pass++;
    n_checks++; if (conflict_cnt !== 32'd0) $display("[TB] FAIL midop_conflict: got %0d want 0", conflict_cnt); else n_pass++;
  endtask

  task automatic test_random();
    bit clash;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst           = ($urandom_range(0, 79) == 0);
      pipe_wb_valid = ($urandom_range(0, 99) < 60);
      pipe_wb_idx   = IW'($urandom_range(0, 7));
      pipe_wb_data  = {$urandom, $urandom};
      mdu_res_valid = ($urandom_range(0, 99) < 35);
      mdu_res_idx   = IW'($urandom_range(0, 7));
      mdu_res_data  = {$urandom, $urandom};
      mdu_iss_idx   = IW'($urandom_range(0, 7));
      clash = 0;
      foreach (m_q[i]) if (m_q[i].idx == mdu_iss_idx) clash = 1;
      mdu_iss_valid = !clash && ($urandom_range(0, 99) < 30);
      hz_r1_idx     = IW'($urandom_range(0, 7));
      hz_r2_idx     = IW'($urandom_range(0, 7));
      hz_rd_idx     = IW'($urandom_range(0, 7));
      #2;
      model_eval();
      n_checks++; if (rf_wen !== e_wen) $display("[TB] FAIL rand_wen@%0d: got %b want %b", c, rf_wen, e_wen); else n_pass++;
      if (e_wen) begin
        n_checks++; if (wr_indx !== e_idx || wr_data !== e_data) $display("[TB] FAIL rand_write@%0d: got %0d/%h want %0d/%h", c, wr_indx, wr_data, e_idx, e_data); else n_pass++;
      end
      n_checks++; if (pipe_wb_ready !== e_ready) $display("[TB] FAIL rand_pipe_ready@%0d: got %b want %b", c, pipe_wb_ready, e_ready); else n_pass++;
      n_checks++; if (mdu_res_ready !== e_res_ready) $display("[TB] FAIL rand_res_ready@%0d: got %b want %b", c, mdu_res_ready, e_res_ready); else n_pass++;
      n_checks++; if (mdu_iss_ready !== e_iss_ready) $display("[TB] FAIL rand_iss_ready@%0d: got %b want %b", c, mdu_iss_ready, e_iss_ready); else n_pass++;
      n_checks++; if (hz_stall !== e_stall) $display("[TB] FAIL rand_stall@%0d: got %b want %b", c, hz_stall, e_stall); else n_pass++;
      n_checks++; if (conflict_cnt !== 32'(m_conf)) $display("[TB] FAIL rand_conflict@%0d: got %0d want %0d", c, conflict_cnt, m_conf); else n_pass++;
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_pend = '0; m_starve = 0; m_conf = 0;
    @(posedge clk);
    #2;
    test_reset();
    test_pipe_only();
    test_contention();
    test_scoreboard();
    test_x0();
    test_full();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
